// File: rtl/sykom_bus_pkg.sv
// Shared constants for the SYKOM bus master:
// bus widths, FSM state codes, GPIO register map.
package sykom_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SETUP  = 3'd1;
  localparam state_t ST_STROBE = 3'd2;
  localparam state_t ST_HOLD   = 3'd3;
  localparam state_t ST_RESP   = 3'd4;

  localparam logic [15:0] GPIO_A    = 16'h1094;
  localparam logic [15:0] GPIO_B    = 16'h1098;
  localparam logic [15:0] GPIO_CTRL = 16'h109C;

  localparam int CTRL_START = 8;
  localparam int CTRL_STOP  = 6;
  localparam int CTRL_BS    = 3;

endpackage

// File: rtl/sykom_bus_phase_timer.sv
// Loadable 8-bit down-counter; done while the count sits at zero.
// Loading N-1 gives a phase of exactly N cycles.
module sykom_bus_phase_timer (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       done_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = load_val_i;
    else if (count_q != 8'd0)
      count_d = count_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!n_reset)
      count_q <= 8'd0;
    else
      count_q <= count_d;
  end

  assign done_o = (count_q == 8'd0);

endmodule

// File: rtl/sykom_bus_master.sv
// SYKOM bus master: one read/write at a time with
// setup, strobe and hold phases; read data on a response handshake.
module sykom_bus_master
  import sykom_bus_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] saddress,
  output logic [DATA_W-1:0] sdata_out,
  input  logic [DATA_W-1:0] sdata_in,
  output logic              srd,
  output logic              swr,
  output logic              busy
);

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYCLES - 1);

  state_t            state_q, state_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              srd_q, srd_d;
  logic              swr_q, swr_d;
  logic              rv_q, rv_d;
  logic              tmr_load;
  logic [7:0]        tmr_val;
  logic              tmr_done;

  sykom_bus_phase_timer u_timer (
    .clk        (clk),
    .n_reset    (n_reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Strobe next-values follow the phase transition so the
  // registered strobes line up exactly with STROBE.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    srd_d    = srd_q;
    swr_d    = swr_q;
    rv_d     = rv_q;
    tmr_load = 1'b0;
    tmr_val  = SETUP_LD;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d  = ST_SETUP;
          op_d     = cmd_write;
          addr_d   = cmd_addr;
          if (cmd_write)
            wdata_d = cmd_wdata;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          state_d  = ST_STROBE;
          srd_d    = !op_q;
          swr_d    = op_q;
          tmr_load = 1'b1;
          tmr_val  = STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (tmr_done) begin
          state_d  = ST_HOLD;
          srd_d    = 1'b0;
          swr_d    = 1'b0;
          if (!op_q)
            rdata_d = sdata_in;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
          if (op_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RESP;
            rv_d    = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          rv_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        srd_d   = 1'b0;
        swr_d   = 1'b0;
        rv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      srd_q   <= 1'b0;
      swr_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      srd_q   <= srd_d;
      swr_q   <= swr_d;
      rv_q    <= rv_d;
    end
  end

  assign cmd_ready = n_reset && (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rv_q;
  assign rsp_rdata = rdata_q;
  assign saddress  = addr_q;
  assign sdata_out = wdata_q;
  assign srd       = srd_q;
  assign swr       = swr_q;

endmodule

// File: tb/tb_sykom_bus_master.sv
// Bench for sykom_bus_master: directed phase checks plus random
// traffic against a word-memory reference of the slave.
module tb_sykom_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [15:0] saddress;
  logic [31:0] sdata_out, sdata_in;
  logic        srd, swr, busy;

  logic        b_cmd_valid, b_cmd_ready, b_cmd_write;
  logic [15:0] b_cmd_addr;
  logic [31:0] b_cmd_wdata;
  logic        b_rsp_valid, b_rsp_ready;
  logic [31:0] b_rsp_rdata;
  logic [15:0] b_saddress;
  logic [31:0] b_sdata_out, b_sdata_in;
  logic        b_srd, b_swr, b_busy;

  sykom_bus_master dut (
    .clk(clk), .n_reset(n_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .saddress(saddress), .sdata_out(sdata_out),
    .sdata_in(sdata_in),
    .srd(srd), .swr(swr), .busy(busy)
  );

  sykom_bus_master #(
    .SETUP_CYCLES(2), .STROBE_CYCLES(4), .HOLD_CYCLES(3)
  ) dut_b (
    .clk(clk), .n_reset(n_reset),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_write(b_cmd_write), .cmd_addr(b_cmd_addr),
    .cmd_wdata(b_cmd_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata),
    .saddress(b_saddress), .sdata_out(b_sdata_out),
    .sdata_in(b_sdata_in),
    .srd(b_srd), .swr(b_swr), .busy(b_busy)
  );

  // Slave: 16 words at 0x1080..0x10BC, reset to index+1.
  logic [31:0] smem [16];
  always @(posedge clk) begin
    if (!n_reset) begin
      for (int i = 0; i < 16; i++) smem[i] <= 32'(i) + 32'd1;
    end else if (swr) begin
      smem[saddress[5:2]] <= sdata_out;
    end
  end
  assign sdata_in   = srd ? smem[saddress[5:2]] : 32'hDEAD_BEEF;
  assign b_sdata_in = b_srd ? 32'hC0DE_1098 : 32'h0;

  logic [31:0] ref_mem [16];
  int tests = 0;
  int fails = 0;

  function automatic void init_ref();
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'(i) + 32'd1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns positioned on cycle 1 after the handshake edge.
  task automatic send(input logic w, input logic [15:0] a,
                      input logic [31:0] d);
    int n;
    n = 0;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    chk("hs_wait", 64'(n < 50), 64'd1);
    step();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = 16'($urandom);
    cmd_wdata = $urandom;
    if (w) ref_mem[a[5:2]] = d;
  endtask

  initial begin
    int gap, sw1, sw2, lat, nst;
    logic w;
    logic [3:0] idx;
    logic [15:0] a;
    logic [31:0] d, exp;

    n_reset   = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr  = '0;   cmd_wdata = '0;
    rsp_ready = 1'b1;
    b_cmd_valid = 1'b0; b_cmd_write = 1'b0;
    b_cmd_addr  = '0;   b_cmd_wdata = '0;
    b_rsp_ready = 1'b1;
    init_ref();
    step();
    step();
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk("rst_outs", {saddress, sdata_out, srd, swr, rsp_valid, busy}, 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    n_reset = 1'b1;
    step();
    chk("idle_ready", 64'(cmd_ready), 64'd1);

    send(1'b1, 16'h1094, 32'h0000_0120);
    for (int c = 1; c <= 5; c++) begin
      if (c <= 4)
        chk("t1_bus", {saddress, sdata_out}, {16'h1094, 32'h120});
      chk("t1_swr", 64'(swr), 64'(c == 2 || c == 3));
      chk("t1_srd", 64'(srd), 64'd0);
      chk("t1_ready", 64'(cmd_ready), 64'(c == 5));
      if (c < 5) step();
    end

    send(1'b0, 16'h109C, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      chk("t2_rv", 64'(rsp_valid), 64'(c == 5));
      if (c < 5) step();
    end
    chk("t2_rdata", 64'(rsp_rdata), 64'h8);
    step();
    chk("t2_idle", 64'(cmd_ready), 64'd1);

    rsp_ready = 1'b0;
    send(1'b0, 16'h1094, 32'h0);
    repeat (4) step();
    for (int i = 0; i < 6; i++) begin
      chk("t3_rv", 64'(rsp_valid), 64'd1);
      chk("t3_rdata", 64'(rsp_rdata), 64'h120);
      chk("t3_ready", 64'(cmd_ready), 64'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("t3_rv_drop", 64'(rsp_valid), 64'd0);
    chk("t3_idle", 64'(cmd_ready), 64'd1);

    cmd_write = 1'b1; cmd_addr = 16'h1094;
    cmd_wdata = 32'hA1; cmd_valid = 1'b1;
    step();
    cmd_addr = 16'h1098; cmd_wdata = 32'hB2;
    ref_mem[5] = 32'hA1;
    gap = 1; sw1 = 0;
    while (!cmd_ready && gap < 20) begin
      sw1 += int'(swr);
      step();
      gap++;
    end
    chk("t4_gap", 64'(gap), 64'd5);
    step();
    cmd_valid = 1'b0;
    ref_mem[6] = 32'hB2;
    sw2 = 0;
    for (int c = 1; c <= 5; c++) begin
      sw2 += int'(swr);
      if (c <= 4)
        chk("t4_bus2", {saddress, sdata_out}, {16'h1098, 32'hB2});
      step();
    end
    chk("t4_swr1", 64'(sw1), 64'd2);
    chk("t4_swr2", 64'(sw2), 64'd2);

    send(1'b1, 16'h10A0, 32'h55);
    step();
    chk("t5_swr_on", 64'(swr), 64'd1);
    n_reset = 1'b0;
    step();
    init_ref();
    chk("t5_swr", 64'(swr), 64'd0);
    chk("t5_addr", 64'(saddress), 64'd0);
    chk("t5_rv_busy", {rsp_valid, busy}, 64'd0);
    n_reset = 1'b1;
    step();
    chk("t5_ready", 64'(cmd_ready), 64'd1);

    b_cmd_write = 1'b0; b_cmd_addr = 16'h1098; b_cmd_valid = 1'b1;
    chk("t6_ready", 64'(b_cmd_ready), 64'd1);
    step();
    b_cmd_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      chk("t6_srd", 64'(b_srd), 64'(c >= 3 && c <= 6));
      chk("t6_rv", 64'(b_rsp_valid), 64'(c == 10));
      if (c < 10) step();
    end
    chk("t6_rdata", 64'(b_rsp_rdata), 64'hC0DE_1098);
    step();

    for (int k = 0; k < 40; k++) begin
      w   = 1'($urandom_range(0, 1));
      idx = 4'($urandom_range(0, 15));
      a   = {10'h042, idx, 2'b00};
      d   = $urandom;
      exp = ref_mem[idx];
      if (!w) rsp_ready = 1'b0;
      send(w, a, d);
      lat = 1; nst = 0;
      if (w) begin
        while (!cmd_ready && lat < 30) begin
          nst += int'(swr);
          step();
          lat++;
        end
        chk("rnd_wlat", 64'(lat), 64'd5);
        chk("rnd_wstb", 64'(nst), 64'd2);
      end else begin
        while (!rsp_valid && lat < 30) begin
          nst += int'(srd);
          step();
          lat++;
        end
        chk("rnd_rlat", 64'(lat), 64'd5);
        chk("rnd_rstb", 64'(nst), 64'd2);
        chk("rnd_rdata", 64'(rsp_rdata), 64'(exp));
        repeat ($urandom_range(0, 3)) step();
        rsp_ready = 1'b1;
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
